alu32: RTL and testbench
========================

# alu32

Registered 32-bit arithmetic/logic unit for the datapath execute stage. It adds, subtracts, shifts by a 5-bit immediate amount, and performs bitwise AND/OR on two 32-bit sources, selected by a 6-bit function code. It drives a 32-bit result plus zero and carry flags, all registered one clock after the operands are sampled.

## Interface
- No parameters; the datapath width is fixed at 32.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- Src1  input  32  first operand; also the shift source
- Src2  input  32  second operand; ignored for shifts
- funct  input  6  operation select
- shamt  input  5  shift amount, 0..31
- result  output  32  registered operation result
- zero  output  1  registered flag, 1 when the computed result is 0
- carry  output  1  registered carry/borrow flag

## Operation
- funct 27 ADD: result = Src1 + Src2, modulo 2^32. carry = bit 32 of the 33-bit sum.
- funct 28 SUB: result = Src1 + ~Src2 + 1, modulo 2^32. carry = carry-out of that sum, so carry = 1 when Src1 >= Src2 unsigned (no borrow).
- funct 29 SLL: result = Src1 << shamt, zero-filled. carry = last bit shifted out, which is Src1[32-shamt]; carry = 0 when shamt = 0.
- funct 30 SRL: result = Src1 >> shamt, logical and zero-filled. carry = Src1[shamt-1]; carry = 0 when shamt = 0.
- funct 31 AND: result = Src1 & Src2. carry = 0.
- funct 32 OR: result = Src1 | Src2. carry = 0.
- Any other funct, including 0: result = 0, carry = 0.
- zero = (next result == 0). It is computed from the same combinational value that is loaded into result.
- All operands are treated as unsigned. No overflow flag is produced.
- The shifter is a 5-stage barrel shifter. The adder and subtractor share one 32-bit adder with conditional inversion of Src2.

## Timing
- On every rising clk edge with rst = 0, the combinational value of f(Src1, Src2, funct, shamt) is loaded into result, zero and carry.
- Latency is 1 cycle. There is no handshake; a new operation can be issued every cycle.
- While rst = 1, asynchronously and independently of clk: result = 0, zero = 0, carry = 0.
- If reset is asserted mid-operation, the in-flight result is discarded.
- The first valid output appears on the first rising edge after rst deasserts.
- Input changes between edges have no effect on the outputs until the next edge.

## Configuration
- Macro ALU32_ROTATE_EN.
- When defined, two extra operations are compiled in:
  - funct 33 ROTL: result = Src1 rotated left by shamt.
  - funct 34 ROTR: result = Src1 rotated right by shamt.
  - For both, carry = the last bit rotated across the word boundary, and carry = 0 when shamt = 0.
- When not defined, funct 33 and 34 behave as unknown codes: result = 0, carry = 0, zero = 1.

## Test plan
- Reset: assert rst with arbitrary inputs -> result = 0, zero = 0, carry = 0, with no clk edge required.
- ADD: Src1 = 0x80000000, Src2 = 0x80000000, funct 27 -> result = 0, zero = 1, carry = 1. Then Src1 = 25, Src2 = 19 -> result = 44, zero = 0, carry = 0.
- SUB: Src1 = 25, Src2 = 19, funct 28 -> result = 6, carry = 1. Then Src1 = Src2 = 64 -> result = 0, zero = 1, carry = 1.
- Shifts on Src1 = 64:
  - funct 29: shamt 1 -> 128; shamt 2 -> 256.
  - funct 30: shamt 1 -> 32; shamt 2 -> 16.
  - carry = 0 in all four cases.
- Logic:
  - funct 31, Src1 = 3, Src2 = 6 -> result = 2.
  - funct 32, Src1 = 3, Src2 = 5 -> result = 7.
  - funct 0 -> result = 0, zero = 1, carry = 0.
  - Each output is checked exactly one edge after its input is applied.
- With ALU32_ROTATE_EN defined: funct 33, Src1 = 0x80000001, shamt 1 -> result = 0x00000003, carry = 1. Without the macro, the same stimulus -> result = 0.

Source files
------------

// File: rtl/alu32.sv
// rtl/alu32.sv - registered 32-bit ALU (add/sub/shift/and/or); optional rotates under ALU32_ROTATE_EN
module alu32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry
);

    localparam logic [5:0] F_ADD = 6'd27;
    localparam logic [5:0] F_SUB = 6'd28;
    localparam logic [5:0] F_SLL = 6'd29;
    localparam logic [5:0] F_SRL = 6'd30;
    localparam logic [5:0] F_AND = 6'd31;
    localparam logic [5:0] F_OR  = 6'd32;
`ifdef ALU32_ROTATE_EN
    localparam logic [5:0] F_ROTL = 6'd33;
    localparam logic [5:0] F_ROTR = 6'd34;
`endif

    // 33-bit barrel shifters: the extra bit catches the last bit shifted out,
    // which naturally reads 0 when the amount is 0.
    function automatic logic [32:0] barrel_left(input logic [32:0] v, input logic [4:0] s);
        logic [32:0] t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (s[i]) t = t << (1 << i);
        end
        return t;
    endfunction

    function automatic logic [32:0] barrel_right(input logic [32:0] v, input logic [4:0] s);
        logic [32:0] t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (s[i]) t = t >> (1 << i);
        end
        return t;
    endfunction

`ifdef ALU32_ROTATE_EN
    function automatic logic [31:0] rotate_left(input logic [31:0] v, input logic [4:0] s);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (s[i]) t = (t << (1 << i)) | (t >> (32 - (1 << i)));
        end
        return t;
    endfunction

    function automatic logic [31:0] rotate_right(input logic [31:0] v, input logic [4:0] s);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (s[i]) t = (t >> (1 << i)) | (t << (32 - (1 << i)));
        end
        return t;
    endfunction
`endif

    logic        sub_op;
    logic [31:0] addend;
    logic [32:0] sum;
    logic [32:0] shl;
    logic [32:0] shr;
    logic [31:0] res_next;
    logic        carry_next;
`ifdef ALU32_ROTATE_EN
    logic [31:0] rotl;
    logic [31:0] rotr;
`endif

    // Shared adder: subtraction is Src1 + ~Src2 + 1, carry-out means no borrow.
    assign sub_op = (funct == F_SUB);
    assign addend = sub_op ? ~Src2 : Src2;
    assign sum    = {1'b0, Src1} + {1'b0, addend} + {32'd0, sub_op};
    assign shl    = barrel_left({1'b0, Src1}, shamt);
    assign shr    = barrel_right({Src1, 1'b0}, shamt);
`ifdef ALU32_ROTATE_EN
    assign rotl   = rotate_left(Src1, shamt);
    assign rotr   = rotate_right(Src1, shamt);
`endif

    always_comb begin
        res_next   = 32'd0;
        carry_next = 1'b0;
        case (funct)
            F_ADD, F_SUB: begin
                res_next   = sum[31:0];
                carry_next = sum[32];
            end
            F_SLL: begin
                res_next   = shl[31:0];
                carry_next = shl[32];
            end
            F_SRL: begin
                res_next   = shr[32:1];
                carry_next = shr[0];
            end
            F_AND: res_next = Src1 & Src2;
            F_OR:  res_next = Src1 | Src2;
`ifdef ALU32_ROTATE_EN
            // The last bit across the boundary lands in bit 0 (left) or bit 31 (right).
            F_ROTL: begin
                res_next   = rotl;
                carry_next = (shamt != 5'd0) & rotl[0];
            end
            F_ROTR: begin
                res_next   = rotr;
                carry_next = (shamt != 5'd0) & rotr[31];
            end
`endif
            default: begin
                res_next   = 32'd0;
                carry_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 32'd0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else begin
            result <= res_next;
            zero   <= (res_next == 32'd0);
            carry  <= carry_next;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// tb/tb_alu32.sv - table-driven self-checking bench for alu32
module tb_alu32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        carry;

    int errors = 0;
    int checks = 0;

    alu32 dut (
        .clk    (clk),
        .rst    (rst),
        .Src1   (Src1),
        .Src2   (Src2),
        .funct  (funct),
        .shamt  (shamt),
        .result (result),
        .zero   (zero),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [5:0]  fn;
        logic [4:0]  sa;
        logic [31:0] e_res;
        logic        e_zero;
        logic        e_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] r, input logic z, input logic c);
        checks++;
        if (result !== r || zero !== z || carry !== c) begin
            errors++;
            $display("FAIL %s: got result=%h zero=%b carry=%b, want result=%h zero=%b carry=%b",
                     name, result, zero, carry, r, z, c);
        end
    endtask

    task automatic apply(input logic [31:0] s1, input logic [31:0] s2, input logic [5:0] fn, input logic [4:0] sa);
        @(negedge clk);
        Src1  = s1;
        Src2  = s2;
        funct = fn;
        shamt = sa;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{"add_wrap",   32'h80000000, 32'h80000000, 6'd27, 5'd0, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"add_small",  32'd25,       32'd19,       6'd27, 5'd0, 32'd44,       1'b0, 1'b0});
        vecs.push_back('{"sub_pos",    32'd25,       32'd19,       6'd28, 5'd0, 32'd6,        1'b0, 1'b1});
        vecs.push_back('{"sub_equal",  32'd64,       32'd64,       6'd28, 5'd0, 32'd0,        1'b1, 1'b1});
        vecs.push_back('{"sub_borrow", 32'd19,       32'd25,       6'd28, 5'd0, 32'hFFFFFFFA, 1'b0, 1'b0});
        vecs.push_back('{"sll_1",      32'd64,       32'hDEAD,     6'd29, 5'd1, 32'd128,      1'b0, 1'b0});
        vecs.push_back('{"sll_2",      32'd64,       32'hDEAD,     6'd29, 5'd2, 32'd256,      1'b0, 1'b0});
        vecs.push_back('{"srl_1",      32'd64,       32'hBEEF,     6'd30, 5'd1, 32'd32,       1'b0, 1'b0});
        vecs.push_back('{"srl_2",      32'd64,       32'hBEEF,     6'd30, 5'd2, 32'd16,       1'b0, 1'b0});
        vecs.push_back('{"sll_out",    32'h80000000, 32'd0,        6'd29, 5'd1, 32'd0,        1'b1, 1'b1});
        vecs.push_back('{"sll_0",      32'h80000001, 32'd0,        6'd29, 5'd0, 32'h80000001, 1'b0, 1'b0});
        vecs.push_back('{"sll_31",     32'h00000003, 32'd0,        6'd29, 5'd31, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{"srl_out",    32'h00000001, 32'd0,        6'd30, 5'd1, 32'd0,        1'b1, 1'b1});
        vecs.push_back('{"srl_0",      32'h80000001, 32'd0,        6'd30, 5'd0, 32'h80000001, 1'b0, 1'b0});
        vecs.push_back('{"srl_31",     32'hC0000000, 32'd0,        6'd30, 5'd31, 32'h00000001, 1'b0, 1'b1});
        vecs.push_back('{"and",        32'd3,        32'd6,        6'd31, 5'd0, 32'd2,        1'b0, 1'b0});
        vecs.push_back('{"or",         32'd3,        32'd5,        6'd32, 5'd0, 32'd7,        1'b0, 1'b0});
        vecs.push_back('{"and_zero",   32'hF0F0F0F0, 32'h0F0F0F0F, 6'd31, 5'd0, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{"funct0",     32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0,  5'd3, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{"funct63",    32'h12345678, 32'h1,        6'd63, 5'd3, 32'd0,        1'b1, 1'b0});
`ifdef ALU32_ROTATE_EN
        vecs.push_back('{"rotl_1",     32'h80000001, 32'd0,        6'd33, 5'd1, 32'h00000003, 1'b0, 1'b1});
        vecs.push_back('{"rotr_1",     32'h80000001, 32'd0,        6'd34, 5'd1, 32'hC0000000, 1'b0, 1'b1});
        vecs.push_back('{"rotl_0",     32'h80000001, 32'd0,        6'd33, 5'd0, 32'h80000001, 1'b0, 1'b0});
        vecs.push_back('{"rotr_4",     32'h0000001E, 32'd0,        6'd34, 5'd4, 32'hE0000001, 1'b0, 1'b1});
`else
        vecs.push_back('{"rotl_off",   32'h80000001, 32'd0,        6'd33, 5'd1, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{"rotr_off",   32'h80000001, 32'd0,        6'd34, 5'd1, 32'd0,        1'b1, 1'b0});
`endif

        // Async reset: outputs clear with no clock edge while inputs hold a nonzero op.
        Src1 = 32'd25; Src2 = 32'd19; funct = 6'd27; shamt = 5'd0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("pre_reset", 32'd44, 1'b0, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("reset_async", 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_held", 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_after_reset", 32'd44, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].s1, vecs[i].s2, vecs[i].fn, vecs[i].sa);
            check(vecs[i].name, vecs[i].e_res, vecs[i].e_zero, vecs[i].e_carry);
        end

        // Inputs changed between edges must not disturb the registered outputs.
        apply(32'd25, 32'd19, 6'd28, 5'd0);
        Src1 = 32'd1; Src2 = 32'd2; funct = 6'd32;
        #2;
        check("hold_between_edges", 32'd6, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("after_next_edge", 32'd3, 1'b0, 1'b0);

        // Reset mid-stream discards the in-flight result.
        @(negedge clk);
        Src1 = 32'hFFFFFFFF; Src2 = 32'd1; funct = 6'd27;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("reset_discard", 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("resume_add_carry", 32'd0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
